// File: rtl/seg4_scan_sched_pkg.sv
// Shared types, constants and helpers for the 4-digit 7-segment scan scheduler.
package seg4_pkg;
  localparam int N_DIGITS = 4;
  localparam int CNT_W = 20;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  typedef logic [N_DIGITS-1:0][3:0] bank_t;

  function automatic logic [3:0] an_onehot(input logic [1:0] idx);
    logic [3:0] sel;
    sel = 4'b0001 << idx;
    return ~sel;
  endfunction

  // A digit is hidden when it and every more significant digit are zero.
  function automatic logic lz_hidden(input bank_t bank, input logic [1:0] idx);
    logic hide;
    case (idx)
      2'd3: hide = (bank[3] == 4'd0);
      2'd2: hide = (bank[3] == 4'd0) && (bank[2] == 4'd0);
      2'd1: hide = (bank[3] == 4'd0) && (bank[2] == 4'd0) && (bank[1] == 4'd0);
      default: hide = 1'b0;
    endcase
    return hide;
  endfunction
endpackage

// File: rtl/seg4_scan_sched_if.sv
// Host write channel into the digit shadow bank.
interface seg4_scan_sched_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/seg4_scan_sched_slot_timer.sv
// Per-slot cycle counter: flags end of dead time, end of slot, and end of slot one cycle ahead.
module seg4_slot_timer
  import seg4_pkg::*;
#(
  parameter int SCAN_DIV = 25000,
  parameter int DEAD_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic dead_done_o,
  output logic slot_end_o,
  output logic slot_end_nxt_o
);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear or advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign dead_done_o    = (cnt_q == DEAD_LAST);
  assign slot_end_o     = (cnt_q == SLOT_LAST);
  assign slot_end_nxt_o = (cnt_d == SLOT_LAST);
endmodule

// File: rtl/seg4_scan_sched.sv
// Scan scheduler: double-banked digit store, blank/show slot FSM, leading-zero suppression.
module seg4_scan_sched
  import seg4_pkg::*;
#(
  parameter int SCAN_DIV = 25000,
  parameter int DEAD_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                lz_sup,
  seg4_scan_sched_if.slave    wr,
  output logic [3:0]          num,
  output logic [3:0]          an,
  output logic                frame_tick
);
  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  bank_t      shadow_q, shadow_d;
  bank_t      active_q, active_d;
  logic [3:0] num_q, num_d;
  logic [3:0] an_q, an_d;
  logic       tick_q, tick_d;
  logic       ready_q, ready_d;

  logic       cnt_clr_s;
  logic       dead_done_s;
  logic       slot_end_s;
  logic       slot_end_nxt_s;
  logic       wr_fire_s;

  assign cnt_clr_s = (state_q == IDLE) || !en || slot_end_s;
  assign wr_fire_s = wr.wr_valid && ready_q;

  seg4_slot_timer #(
    .SCAN_DIV (SCAN_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .clr_i          (cnt_clr_s),
    .dead_done_o    (dead_done_s),
    .slot_end_o     (slot_end_s),
    .slot_end_nxt_o (slot_end_nxt_s)
  );

  // Slot sequencing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = 2'd0;
        if (en) state_d = BLANK;
        else    state_d = IDLE;
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else if (dead_done_s) begin
          state_d = SHOW;
        end else begin
          state_d = BLANK;
        end
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else if (slot_end_s) begin
          state_d = BLANK;
          idx_d   = idx_q + 2'd1;
        end else begin
          state_d = SHOW;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Banks and registered outputs are all derived from the next state, so they line up with it.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_fire_s) shadow_d[wr.wr_addr] = wr.wr_data;
    else           shadow_d = shadow_q;

    if ((state_q == IDLE) || tick_q) active_d = shadow_q;
    else                             active_d = active_q;

    tick_d  = (state_d == SHOW) && (idx_d == 2'd3) && slot_end_nxt_s;
    ready_d = !tick_d;
    num_d   = active_d[idx_d];

    if ((state_d == SHOW) && !(lz_sup && lz_hidden(active_d, idx_d))) an_d = an_onehot(idx_d);
    else                                                              an_d = AN_OFF;
  end

  // State, bank and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      shadow_q <= '0;
      active_q <= '0;
      num_q    <= 4'd0;
      an_q     <= AN_OFF;
      tick_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      num_q    <= num_d;
      an_q     <= an_d;
      tick_q   <= tick_d;
      ready_q  <= ready_d;
    end
  end

  assign num         = num_q;
  assign an          = an_q;
  assign frame_tick  = tick_q;
  assign wr.wr_ready = ready_q;
endmodule

// File: tb/tb_seg4_scan_sched.sv
// Directed bench for seg4_scan_sched with SCAN_DIV=8, DEAD_CYC=2 and a cycle-level expectation model.
module tb_seg4_scan_sched;
  localparam int SD = 8;
  localparam int DC = 2;
  localparam int FR = 4 * SD;

  logic       clk;
  logic       rst;
  logic       en;
  logic       lz_sup;
  logic [3:0] num;
  logic [3:0] an;
  logic       frame_tick;

  seg4_scan_sched_if wr_if ();

  seg4_scan_sched #(
    .SCAN_DIV (SD),
    .DEAD_CYC (DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lz_sup     (lz_sup),
    .wr         (wr_if.slave),
    .num        (num),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expectation model state
  int         m_ph;
  logic       m_rst;
  logic       m_lz;
  logic       m_ft;
  logic       m_rdy;
  logic [3:0] m_active [4];
  logic [3:0] m_shadow [4];
  int         ft_seen;
  int         lit_cnt [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check all outputs.
  task automatic cyc();
    logic       acc;
    logic       show;
    logic       hidden;
    int         slot;
    logic [3:0] e_an;
    logic [3:0] e_num;
    logic [3:0] sel;
    acc = wr_if.wr_valid && m_rdy;
    if (!rst) begin
      m_ph  = -1;
      m_rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
        m_active[k] = 4'd0;
        m_shadow[k] = 4'd0;
      end
    end else begin
      if (m_ph < 0 || m_ft) begin
        for (int k = 0; k < 4; k++) m_active[k] = m_shadow[k];
      end
      if (acc) m_shadow[wr_if.wr_addr] = wr_if.wr_data;
      if (!en)           m_ph = -1;
      else if (m_ph < 0) m_ph = 0;
      else               m_ph = m_ph + 1;
      m_lz  = lz_sup;
      m_rst = 1'b0;
    end
    @(posedge clk);
    #1;
    if (m_rst) begin
      e_an  = 4'hF;
      e_num = 4'd0;
      m_ft  = 1'b0;
      m_rdy = 1'b0;
    end else begin
      slot   = (m_ph < 0) ? 0 : (m_ph / SD) % 4;
      show   = (m_ph >= 0) && ((m_ph % SD) >= DC);
      hidden = m_lz && (slot > 0);
      for (int j = slot; j < 4; j++) if (m_active[j] != 4'd0) hidden = 1'b0;
      sel    = 4'b0001 << slot;
      e_an   = (show && !hidden) ? ~sel : 4'hF;
      e_num  = m_active[slot];
      m_ft   = (m_ph >= 0) && ((m_ph % FR) == FR - 1);
      m_rdy  = !m_ft;
    end
    chk("an", {28'd0, an}, {28'd0, e_an});
    chk("num", {28'd0, num}, {28'd0, e_num});
    chk("frame_tick", {31'd0, frame_tick}, {31'd0, m_ft});
    chk("wr_ready", {31'd0, wr_if.wr_ready}, {31'd0, m_rdy});
    if (frame_tick === 1'b1) ft_seen++;
    for (int k = 0; k < 4; k++) begin
      sel = 4'b0001 << k;
      if (an === ~sel) lit_cnt[k]++;
    end
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 400; i++) begin
      if (m_ph == target) break;
      cyc();
    end
    chk("reach_phase", m_ph, target);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [3:0] d);
    logic took;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = a;
    wr_if.wr_data  = d;
    for (int i = 0; i < 8; i++) begin
      took = m_rdy;
      cyc();
      if (took) break;
    end
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic clear_lit();
    for (int k = 0; k < 4; k++) lit_cnt[k] = 0;
  endtask

  int base;

  initial begin
    rst = 1'b0; en = 1'b0; lz_sup = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.wr_addr = 2'd0; wr_if.wr_data = 4'd0;
    m_ph = -1; m_rst = 1'b1; m_lz = 1'b0; m_ft = 1'b0; m_rdy = 1'b0;
    ft_seen = 0;
    clear_lit();
    for (int k = 0; k < 4; k++) begin
      m_active[k] = 4'd0;
      m_shadow[k] = 4'd0;
    end

    // reset, then enable: two full frames of schedule
    repeat (3) cyc();
    chk("rst_an", {28'd0, an}, 32'h0000000F);
    chk("rst_rdy", {31'd0, wr_if.wr_ready}, 32'd0);
    rst = 1'b1; en = 1'b1;
    cyc();
    chk("en_blank_an", {28'd0, an}, 32'h0000000F);
    run_until(2);
    chk("en_show_d0", {28'd0, an}, 32'h0000000E);
    run_until(10);
    chk("en_show_d1", {28'd0, an}, 32'h0000000D);
    run_until(FR - 1);
    chk("first_tick", {31'd0, frame_tick}, 32'd1);
    run_until(2 * FR - 1);

    // write 4,3,2,1 mid-frame; shows next frame
    run_until(2 * FR + 10);
    do_write(2'd0, 4'd4);
    do_write(2'd1, 4'd3);
    do_write(2'd2, 4'd2);
    do_write(2'd3, 4'd1);
    run_until(3 * FR - 1);
    chk("wd_old_num", {28'd0, num}, 32'd0);
    run_until(3 * FR);
    chk("wd_d0", {28'd0, num}, 32'd4);
    run_until(3 * FR + 8);
    chk("wd_d1", {28'd0, num}, 32'd3);
    run_until(3 * FR + 16);
    chk("wd_d2", {28'd0, num}, 32'd2);
    run_until(3 * FR + 24);
    chk("wd_d3", {28'd0, num}, 32'd1);

    // write held across the frame_tick cycle
    run_until(4 * FR - 1);
    chk("bnd_tick", {31'd0, frame_tick}, 32'd1);
    chk("bnd_rdy", {31'd0, wr_if.wr_ready}, 32'd0);
    do_write(2'd2, 4'd9);
    run_until(4 * FR + 16);
    chk("bnd_still_old", {28'd0, num}, 32'd2);
    run_until(5 * FR + 16);
    chk("bnd_new", {28'd0, num}, 32'd9);

    // leading-zero suppression with digits 3..0 = 0,0,5,0
    do_write(2'd0, 4'd0);
    do_write(2'd1, 4'd5);
    do_write(2'd2, 4'd0);
    do_write(2'd3, 4'd0);
    lz_sup = 1'b1;
    base = (m_ph / FR + 1) * FR;
    run_until(base - 1);
    clear_lit();
    run_until(base + FR - 1);
    chk("lz_d3_dark", lit_cnt[3], 0);
    chk("lz_d2_dark", lit_cnt[2], 0);
    chk("lz_d1_lit", lit_cnt[1], SD - DC);
    chk("lz_d0_lit", lit_cnt[0], SD - DC);
    lz_sup = 1'b0;
    clear_lit();
    run_until(base + 2 * FR - 1);
    chk("nolz_d3_lit", lit_cnt[3], SD - DC);
    chk("nolz_d2_lit", lit_cnt[2], SD - DC);

    // disable mid-SHOW of digit 2, then re-enable
    run_until(base + 2 * FR + 2 * SD + 4);
    chk("dis_pre_an", {28'd0, an}, 32'h0000000B);
    en = 1'b0;
    ft_seen = 0;
    cyc();
    chk("dis_an", {28'd0, an}, 32'h0000000F);
    repeat (20) cyc();
    chk("dis_no_tick", ft_seen, 0);
    en = 1'b1;
    cyc();
    chk("re_blank", {28'd0, an}, 32'h0000000F);
    run_until(2);
    chk("re_d0", {28'd0, an}, 32'h0000000E);

    // reset while digit 1 lit; pending shadow write is lost
    do_write(2'd0, 4'd7);
    run_until(SD + 4);
    chk("pre_rst_an", {28'd0, an}, 32'h0000000D);
    rst = 1'b0;
    cyc();
    chk("mid_rst_an", {28'd0, an}, 32'h0000000F);
    chk("mid_rst_num", {28'd0, num}, 32'd0);
    chk("mid_rst_rdy", {31'd0, wr_if.wr_ready}, 32'd0);
    rst = 1'b1;
    cyc();
    run_until(2);
    chk("post_rst_num", {28'd0, num}, 32'd0);
    chk("post_rst_an", {28'd0, an}, 32'h0000000E);
    run_until(FR + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg4_scan_sched.md
# seg4_scan_sched

Scan scheduler for the 4-digit multiplexed 7-segment display. It holds the four digit values and sequences them one digit at a time onto the shared `num`/`an` pins feeding the 7-segment decoder. Each digit slot starts with anode dead time to prevent ghosting, and leading zeros can be suppressed. Host writes land in a shadow bank that is copied to the display bank only at frame boundaries, so a frame never shows a mix of old and new values.

## Interface
- `SCAN_DIV`, 25000: clock cycles per digit slot; range 4..2^20; at 100 MHz this gives a 1 kHz frame rate.
- `DEAD_CYC`, 16: blanking cycles at the start of each slot; must satisfy 1 ≤ `DEAD_CYC` < `SCAN_DIV`.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-low reset.
- `en` in 1: display enable.
- `lz_sup` in 1: leading-zero suppression enable.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accept.
- `wr_addr` in 2: digit index; 0 is the least significant digit and drives `an[0]`.
- `wr_data` in 4: digit value, 0–15.
- `num` out 4: value of the digit in the current slot, to the decoder.
- `an` out 4: anode selects, active-low; `4'b1111` means all off.
- `frame_tick` out 1: one-cycle pulse on the last cycle of the digit-3 slot.

## Operation
- **Reset values** (`rst`=0 at an edge): `an`=1111, `num`=0, `wr_ready`=0, `frame_tick`=0, state=IDLE, `idx`=0, `cnt`=0, shadow and active banks all 0.
- **Write handshake:** a write is accepted when `wr_valid`&&`wr_ready` at an edge; `shadow[wr_addr]<=wr_data`. `wr_ready` is 1 in every cycle except reset and any cycle with `frame_tick`=1.
- **Bank copy:** on the `frame_tick` edge, active bank <= shadow bank. A write presented in that cycle is not accepted and must be held.
- **FSM states:** IDLE, BLANK, SHOW.
  - IDLE: `an`=1111, `cnt`=0, `idx`=0. Goes to BLANK when `en`=1.
  - BLANK: `an`=1111, `num`=`active[idx]`. Goes to SHOW when `cnt`==`DEAD_CYC`-1.
  - SHOW: `an`=~(1<<`idx`), unless the digit is suppressed, in which case `an`=1111.
  - At `cnt`==`SCAN_DIV`-1: `cnt`<=0, `idx`<=`idx`+1 mod 4, state goes to BLANK.
- **Counter and index rules:**
  - `cnt` is 20 bits, increments every cycle outside IDLE, and resets to 0 at slot end.
  - `idx` wraps from 3 to 0; this wrap is the frame boundary.
- **Leading-zero suppression:** with `lz_sup`=1, digit k (k=1..3) is suppressed iff `active[3..k]` are all 0. Digit 0 is never suppressed.
- **Disable:** `en`=0 in any state sends the FSM to IDLE on the next edge.
  - The frame is abandoned and no bank copy takes place.
  - Re-enabling restarts at digit 0, in BLANK.
- **Background copy:** while in IDLE, shadow is copied to active every cycle, and `frame_tick` stays 0.

## Timing
- All outputs are registered. The value is visible in cycle n+1 for the state decided at edge n.
- **From `en`=1 onward:**
  - Next cycle: BLANK, `idx`=0, for `DEAD_CYC` cycles.
  - Then SHOW, `an`=1110, for `SCAN_DIV`−`DEAD_CYC` cycles.
  - Then digit 1, and so on.
- Frame length is exactly 4·`SCAN_DIV` cycles. `frame_tick` repeats with that period while enabled.
- **Write latency:** a write accepted in frame F appears on `num` in the first digit-0 BLANK of frame F+1. Worst case is 4·`SCAN_DIV`+1 cycles.
- **Anode overlap:** no cycle has two `an` bits low. Between any two lit digits there are at least `DEAD_CYC` cycles of `an`=1111.
- **Reset during operation:** reset takes effect at the next edge. Outputs return to reset values, and pending shadow contents are lost.

## Structure
- **Package `seg4_pkg`:**
  - State enum {IDLE, BLANK, SHOW}.
  - `N_DIGITS`=4.
  - `AN_OFF`=4'b1111.
  - Function `an_onehot(idx)` returning the active-low select.
- **Sub-module `seg4_slot_timer`:**
  - Contains the `cnt` register plus clear/enable logic.
  - Outputs `dead_done` (`cnt`==`DEAD_CYC`-1) and `slot_end` (`cnt`==`SCAN_DIV`-1).
- **Top level:** the FSM, both banks, suppression logic and the handshake.

## Test plan
All scenarios use `SCAN_DIV`=8 and `DEAD_CYC`=2.
- **Reset and enable:** hold `rst`=0 for 3 cycles, then `rst`=1 and `en`=1.
  - Every cycle up to and including the cycle where `en`=1 is first sampled: `an`=1111, `wr_ready`=0 (reset), `frame_tick`=0.
  - The `an` pattern then repeats 1111×2, 1110×6, 1111×2, 1101×6, … with `frame_tick` every 32 cycles.
- **Write then display:** write 4,3,2,1 to addresses 0..3 mid-frame.
  - `num` keeps the old values until after `frame_tick`.
  - The next frame shows `num`=4,3,2,1 in digit order.
- **Write on a boundary:** hold `wr_valid` with addr 2, data 9 during the `frame_tick` cycle.
  - `wr_ready`=0 in that cycle; the write is accepted in the next cycle.
  - Value 9 appears one frame later.
- **Leading-zero suppression:** active bank = 0,0,5,0 (digits 3..0 as listed) with `lz_sup`=1.
  - Only `an[1]` and `an[0]` ever go low.
  - With `lz_sup`=0, all four digits light.
- **Disable mid-SHOW of digit 2:** drop `en`.
  - `an`=1111 from the next cycle.
  - Re-enabling restarts at digit 0 BLANK.
  - No `frame_tick` is produced for the aborted frame.
- **Reset mid-frame:** assert `rst`=0 for 1 cycle while digit 1 is lit.
  - All outputs return to reset values.
  - After release with `en`=1, digit 0 shows value 0.
